// File: rtl/mul_div_engine.sv
// rtl/mul_div_engine.sv - iterative multiply (MUL_BITS per cycle) and restoring divide engine
module mul_div_engine #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_type,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_STEPS = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0] DIV_STEPS = CW'(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic              neg_res, neg_rem;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;

    logic              s1_signed, s2_signed, s1_neg, s2_neg;
    logic [XLEN-1:0]   s1_mag, s2_mag;
    logic              div_zero, div_ovf, div_special, accept, last_step;
    logic [XLEN-1:0]   special_result;

    assign s1_signed = (req_type == 3'd1) || (req_type == 3'd2) ||
                       (req_type == 3'd4) || (req_type == 3'd6);
    assign s2_signed = (req_type == 3'd1) || (req_type == 3'd4) || (req_type == 3'd6);
    assign s1_neg    = s1_signed & src1[XLEN-1];
    assign s2_neg    = s2_signed & src2[XLEN-1];
    assign s1_mag    = s1_neg ? -src1 : src1;
    assign s2_mag    = s2_neg ? -src2 : src2;

    assign div_zero    = req_type[2] && (src2 == '0);
    assign div_ovf     = req_type[2] && !req_type[0] && (src1 == MOST_NEG) && (&src2);
    assign div_special = div_zero || div_ovf;
    // REM/REMU have req_type[1] set; they pick the remainder-side value
    assign special_result = div_zero ? (req_type[1] ? src1 : '1)
                                     : (req_type[1] ? '0 : src1);

    assign accept    = req_valid && (state == S_IDLE) && !stall && !flush;
    assign last_step = ((state == S_MUL) || (state == S_DIV)) && (count == CW'(1));

    // Multiply step: acc = {partial_hi, remaining multiplier}, shifts right MUL_BITS per step
    logic [XLEN+MUL_BITS-1:0]   mul_sum;
    logic [2*XLEN+MUL_BITS-1:0] mul_wide;
    logic [XLEN:0]              trial;
    logic [2*XLEN-1:0]          div_acc, step_acc, prod;
    logic [XLEN-1:0]            quo_fix, rem_fix, final_result;

    assign mul_sum  = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]} +
                      (XLEN+MUL_BITS)'(opnd) * (XLEN+MUL_BITS)'(acc[MUL_BITS-1:0]);
    assign mul_wide = {mul_sum, acc[XLEN-1:0]};

    // Divide step: acc = {partial remainder, dividend/quotient}
    assign trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
    assign div_acc  = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign step_acc = (state == S_MUL) ? mul_wide[2*XLEN+MUL_BITS-1:MUL_BITS] : div_acc;

    assign prod     = neg_res ? -step_acc : step_acc;
    assign quo_fix  = neg_res ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    assign rem_fix  = neg_rem ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
    assign final_result = op[2]          ? (op[1] ? rem_fix : quo_fix) :
                          (op == 3'd0)   ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else if (!stall) begin
            case (state)
                S_IDLE: if (req_valid) begin
                    if (!req_type[2])     state_next = S_MUL;
                    else if (div_special) state_next = S_DONE;
                    else                  state_next = S_DIV;
                end
                S_MUL, S_DIV: if (count == CW'(1)) state_next = S_DONE;
                S_DONE: if (resp_ready) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_DONE);
        busy       = (state == S_MUL) || (state == S_DIV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            op          <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            opnd        <= '0;
            acc         <= '0;
            resp_result <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (!stall) begin
            if (accept) begin
                op      <= req_type;
                neg_res <= s1_neg ^ s2_neg;
                neg_rem <= s1_neg;
                if (!req_type[2]) begin
                    opnd  <= s1_mag;
                    acc   <= {{XLEN{1'b0}}, s2_mag};
                    count <= MUL_STEPS;
                end else begin
                    opnd <= s2_mag;
                    acc  <= {{XLEN{1'b0}}, s1_mag};
                    if (div_special) begin
                        count       <= '0;
                        resp_result <= special_result;
                    end else begin
                        count <= DIV_STEPS;
                    end
                end
            end else if ((state == S_MUL) || (state == S_DIV)) begin
                acc   <= step_acc;
                count <= count - CW'(1);
                if (last_step) resp_result <= final_result;
            end
        end
    end
endmodule
